postage_maxi_deadlock_watchdog: RTL and testbench
=================================================

// Module: postage_maxi_deadlock_watchdog
// PURPOSE
// Consumes the registered 'block' outputs of the postage_maxi deadlock monitors.
// A transient stall is normal; this block flags a deadlock only when some
// monitor stays blocked for THRESH consecutive cycles.
// It latches which monitors were blocked and counts cycles spent deadlocked.
// It drives a sticky flag for the sim/debug reporting path; software clears it.
// PARAMETERS
// NUM_MON  1     number of monitor block inputs (>=1)
// THRESH   1024  consecutive blocked cycles required to declare deadlock (>=2)
// CNT_W    32    width of persist and stall counters (2**CNT_W > THRESH)
// PORTS
// clock         in   1          sole clock, rising edge
// reset         in   1          asynchronous, active-high
// block_sigs    in   NUM_MON    per-monitor block flags (already registered upstream)
// clear         in   1          synchronous, one-cycle: drop deadlock and restart watch
// deadlock      out  1          sticky deadlock flag
// deadlock_mask out  NUM_MON    block_sigs captured on the declaring cycle
// first_idx     out  max(1,$clog2(NUM_MON))  lowest set index of deadlock_mask
// stall_cycles  out  CNT_W      cycles spent in DEADLOCK, saturating at all-ones
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE.
//   Persist counter, deadlock, deadlock_mask, first_idx and stall_cycles are all 0.
// - any_blk = |block_sigs, sampled each rising edge.
// - FSM states: IDLE, WATCH, DEADLOCK; all outputs are registered.
// - IDLE:
//   - any_blk=1 -> WATCH, persist=1.
//   - otherwise stay, persist=0.
// - WATCH:
//   - any_blk=0 -> IDLE, persist=0.
//   - A different monitor becoming blocked does not restart the count; only the OR matters.
//   - any_blk=1 and persist==THRESH-1 -> DEADLOCK.
//     On that edge: deadlock<=1, deadlock_mask<=block_sigs, first_idx<=its lowest set bit.
//   - Otherwise persist<=persist+1.
// - Latency: with any_blk high from edge k, deadlock reads 1 after edge k+THRESH-1.
//   That is THRESH sampled cycles; no early assertion.
// - DEADLOCK:
//   - Sticky regardless of block_sigs.
//   - stall_cycles increments every cycle, saturating.
//   - Mask and index are frozen.
// - clear has priority over every transition in every state.
//   - Next state IDLE; persist, deadlock, mask, first_idx and stall_cycles all go to 0.
//   - block_sigs in the clear cycle is ignored; re-evaluation starts on the next edge.
// - clear in IDLE or WATCH also zeroes persist (abort partial watch).
// - Reset asserted mid-operation returns immediately to reset values, no pending state.
// - NUM_MON=1: first_idx is a 1-bit constant 0.
// TESTING
// - NUM_MON=4, THRESH=8. block_sigs=4'b0100 for 8 cycles ->
//   deadlock rises after the 8th edge, mask=0100, first_idx=2.
// - block_sigs high 7 cycles, then 0 for 1 cycle, then high 7 cycles -> deadlock stays 0
//   (counter restarts).
// - block_sigs 0001 for 4 cycles then 1000 for 4 cycles (OR continuous) ->
//   deadlock after 8th edge, mask=1000, first_idx=3.
// - In DEADLOCK, drop block_sigs to 0 for 10 cycles ->
//   deadlock stays 1, stall_cycles=10 more than at entry, mask unchanged.
// - clear pulsed in the same cycle block_sigs=1111 while deadlocked ->
//   next cycle deadlock=0, stall_cycles=0; it re-declares after 8 more blocked cycles.
// - CNT_W=4 with 20 cycles held in DEADLOCK -> stall_cycles saturates at 15.
//   Async reset mid-WATCH -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/postage_maxi_deadlock_watchdog_if.sv
// Signal bundle between the postage_maxi deadlock monitors and the watchdog.
// The master drives the block flags and clear; the slave (watchdog) drives the report outputs.
interface postage_maxi_deadlock_watchdog_if #(
    parameter int unsigned NUM_MON = 1,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
);
    logic [NUM_MON-1:0] block_sigs;
    logic               clear;
    logic               deadlock;
    logic [NUM_MON-1:0] deadlock_mask;
    logic [IDX_W-1:0]   first_idx;
    logic [CNT_W-1:0]   stall_cycles;

    modport master (
        output block_sigs,
        output clear,
        input  deadlock,
        input  deadlock_mask,
        input  first_idx,
        input  stall_cycles
    );

    modport slave (
        input  block_sigs,
        input  clear,
        output deadlock,
        output deadlock_mask,
        output first_idx,
        output stall_cycles
    );
endinterface

// File: rtl/postage_maxi_deadlock_watchdog.sv
// Deadlock watchdog: declares a sticky deadlock once any monitor stays blocked for THRESH
// consecutive cycles, latching which monitors were blocked and counting cycles spent deadlocked.
module postage_maxi_deadlock_watchdog #(
    parameter int unsigned NUM_MON = 1,
    parameter int unsigned THRESH  = 1024,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input logic                         clock,
    input logic                         reset,
    postage_maxi_deadlock_watchdog_if.slave mon
);

    if (NUM_MON < 1) begin : g_bad_num_mon
        $error("NUM_MON must be at least 1");
    end
    if (THRESH < 2) begin : g_bad_thresh
        $error("THRESH must be at least 2");
    end
    if ((CNT_W < 32) && ((64'd1 << CNT_W) <= 64'(THRESH))) begin : g_bad_cnt_w
        $error("CNT_W too narrow to count to THRESH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWatch,
        StDeadlock
    } state_e;

    localparam logic [CNT_W-1:0] PersistLast = CNT_W'(THRESH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   persist_q, persist_d;
    logic               deadlock_q, deadlock_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               any_blk;

    // Scan high-to-low so the last hit wins, leaving the lowest set index.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MON-1:0] sigs);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (sigs[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign any_blk = |mon.block_sigs;

    always_comb begin
        state_d    = state_q;
        persist_d  = persist_q;
        deadlock_d = deadlock_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        stall_d    = stall_q;

        if (mon.clear) begin
            // block_sigs in the clear cycle is deliberately ignored.
            state_d    = StIdle;
            persist_d  = '0;
            deadlock_d = 1'b0;
            mask_d     = '0;
            idx_d      = '0;
            stall_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_blk) begin
                        state_d   = StWatch;
                        persist_d = CNT_W'(1);
                    end else begin
                        persist_d = '0;
                    end
                end
                StWatch: begin
                    if (!any_blk) begin
                        state_d   = StIdle;
                        persist_d = '0;
                    end else if (persist_q == PersistLast) begin
                        state_d    = StDeadlock;
                        deadlock_d = 1'b1;
                        mask_d     = mon.block_sigs;
                        idx_d      = lowest_set(mon.block_sigs);
                    end else begin
                        persist_d = persist_q + CNT_W'(1);
                    end
                end
                StDeadlock: begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            persist_q  <= '0;
            deadlock_q <= 1'b0;
            mask_q     <= '0;
            idx_q      <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            persist_q  <= persist_d;
            deadlock_q <= deadlock_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            stall_q    <= stall_d;
        end
    end

    assign mon.deadlock      = deadlock_q;
    assign mon.deadlock_mask = mask_q;
    assign mon.first_idx     = idx_q;
    assign mon.stall_cycles  = stall_q;

endmodule

// File: tb/tb_postage_maxi_deadlock_watchdog.sv
// Scoreboard bench for the deadlock watchdog: directed scenarios plus random block/clear
// traffic, checked against a run-length reference model.
module tb_postage_maxi_deadlock_watchdog;

    localparam int unsigned NUM_MON = 4;
    localparam int unsigned THRESH  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int          STALL_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       dl;
        logic [3:0] mask;
        logic [1:0] idx;
        logic [3:0] stall;
    } exp_t;

    logic clock;
    logic reset;

    postage_maxi_deadlock_watchdog_if #(.NUM_MON(NUM_MON), .CNT_W(CNT_W)) bus ();

    postage_maxi_deadlock_watchdog #(
        .NUM_MON(NUM_MON),
        .THRESH (THRESH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mon  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: length of the current unbroken run of blocked samples.
    int         run     = 0;
    bit         m_dl    = 0;
    logic [3:0] m_mask  = '0;
    int         m_idx   = 0;
    int         m_stall = 0;

    function automatic exp_t got_now();
        exp_t g;
        g.dl    = bus.deadlock;
        g.mask  = bus.deadlock_mask;
        g.idx   = bus.first_idx;
        g.stall = bus.stall_cycles;
        return g;
    endfunction

    task automatic model_reset();
        run     = 0;
        m_dl    = 0;
        m_mask  = '0;
        m_idx   = 0;
        m_stall = 0;
    endtask

    task automatic step(input logic [3:0] blk, input logic clr);
        exp_t e;
        @(negedge clock);
        bus.block_sigs = blk;
        bus.clear      = clr;
        if (clr) begin
            model_reset();
        end else if (m_dl) begin
            if (m_stall < STALL_MAX) m_stall++;
        end else if (blk != 4'b0) begin
            run++;
            if (run >= THRESH) begin
                m_dl   = 1;
                m_mask = blk;
                for (int i = 3; i >= 0; i--) if (blk[i]) m_idx = i;
            end
        end else begin
            run = 0;
        end
        e.dl    = m_dl;
        e.mask  = m_mask;
        e.idx   = 2'(m_idx);
        e.stall = 4'(m_stall);
        exp_q.push_back(e);
    endtask

    task automatic repeat_step(input logic [3:0] blk, input int n);
        for (int i = 0; i < n; i++) step(blk, 1'b0);
    endtask

    task automatic check_zero(input string name);
        exp_t g;
        g = got_now();
        n_cmp++;
        if (g != '0) begin
            n_err++;
            $display("FAIL %s: got dl=%0b mask=%b idx=%0d stall=%0d, want all zero",
                     name, g.dl, g.mask, g.idx, g.stall);
        end
    endtask

    // Monitor: every edge that has a pending expectation is compared 1 time unit later.
    always @(posedge clock) begin
        exp_t e;
        exp_t g;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_now();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL cycle_%0d: got dl=%0b mask=%b idx=%0d stall=%0d, want dl=%0b mask=%b idx=%0d stall=%0d",
                         cyc, g.dl, g.mask, g.idx, g.stall, e.dl, e.mask, e.idx, e.stall);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.block_sigs = '0;
        bus.clear      = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check_zero("reset_state");
        @(negedge clock);
        reset = 1'b0;

        // Single monitor blocked for exactly THRESH cycles.
        repeat_step(4'b0100, 8);
        repeat_step(4'b0100, 2);
        step(4'b0000, 1'b1);

        // One-cycle gap at THRESH-1 restarts the count.
        repeat_step(4'b0110, 7);
        step(4'b0000, 1'b0);
        repeat_step(4'b0001, 7);
        repeat_step(4'b0000, 2);

        // Different monitors hand off while the OR stays high.
        repeat_step(4'b0001, 4);
        repeat_step(4'b1000, 4);

        // Sticky while unblocked; stall counter keeps running.
        repeat_step(4'b0000, 10);

        // Clear wins over all-blocked; re-declare, then saturate the stall counter.
        step(4'b1111, 1'b1);
        repeat_step(4'b1111, 8);
        repeat_step(4'b1111, 20);
        step(4'b0000, 1'b1);

        // Clear in mid-watch aborts the partial count.
        repeat_step(4'b0010, 5);
        step(4'b0010, 1'b1);
        repeat_step(4'b0010, 7);
        step(4'b0000, 1'b0);

        // Random traffic, mostly blocked so deadlocks and clears both occur.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] b;
            logic       c;
            b = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(1, 15)) : 4'b0000;
            c = ($urandom_range(0, 29) == 0);
            step(b, c);
        end
        step(4'b0000, 1'b1);

        // Asynchronous reset in the middle of a watch.
        repeat_step(4'b0010, 4);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset_mid_watch");
        bus.block_sigs = '0;
        bus.clear      = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;

        // Traffic after reset confirms no pending state survived.
        repeat_step(4'b1000, 8);
        repeat_step(4'b0000, 3);

        @(posedge clock);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
